// File: rtl/sym_lane_pipe_pkg.sv
// sym_pkg: function codes and lane-width helper shared by sym_lane and sym_lane_pipe
package sym_pkg;
  typedef enum logic [1:0] {
    SYM_F_ZERO = 2'd0,
    SYM_F_ONE  = 2'd1,
    SYM_F_X    = 2'd2,
    SYM_F_NEGX = 2'd3
  } sym_func_t;
  function automatic int lane_w(input int m, input int n);
    return m + n;
  endfunction
endpackage

// File: rtl/sym_lane_pipe_lane.sv
// sym_lane: combinational per-lane symmetry term; SYM_NEG_SAT_EN saturates -min in mode 3
module sym_lane
  import sym_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 8,
  localparam int W = lane_w(M, N)
) (
  input  logic [W-1:0] x,
  input  logic         sign,
  input  logic [1:0]   func,
  output logic [W-1:0] s
);
  logic [W-1:0] one;
  logic [W-1:0] negx;
  assign one = W'(1) << N;
`ifdef SYM_NEG_SAT_EN
  logic [W:0] neg;
  assign neg  = -{x[W-1], x};
  // only -min overflows: the W+1-bit result then disagrees in its top two bits
  assign negx = (neg[W] != neg[W-1]) ? {1'b0, {(W-1){1'b1}}} : neg[W-1:0];
`else
  assign negx = -x;
`endif
  assign s = !sign             ? '0   :
             func == SYM_F_ONE  ? one :
             func == SYM_F_X    ? x   :
             func == SYM_F_NEGX ? negx : '0;
endmodule

// File: rtl/sym_lane_pipe.sv
// sym_lane_pipe: LANES-wide 2-stage valid/ready pipeline of sym_lane terms (SYM_NEG_SAT_EN honoured in sym_lane)
module sym_lane_pipe
  import sym_pkg::*;
#(
  parameter int M     = 4,
  parameter int N     = 8,
  parameter int LANES = 4,
  localparam int W = lane_w(M, N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_x,
  input  logic [LANES-1:0]   in_sign,
  input  logic [1:0]         in_func,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_s,
  output logic               busy
);
  logic               s1_v, s2_v, s1_adv, s2_adv;
  logic [LANES*W-1:0] s1_x, s_comb;
  logic [LANES-1:0]   s1_sign;
  logic [1:0]         s1_func;
  assign s2_adv    = ~s2_v | out_ready;
  assign s1_adv    = ~s1_v | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;
  assign busy      = s1_v | s2_v;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sym_lane #(.M(M), .N(N)) u_lane (
      .x   (s1_x[i*W +: W]),
      .sign(s1_sign[i]),
      .func(s1_func),
      .s   (s_comb[i*W +: W])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      out_s <= '0;
    end else begin
      if (s1_adv) s1_v <= in_valid;
      if (s1_adv && in_valid) begin
        s1_x    <= in_x;
        s1_sign <= in_sign;
        s1_func <= in_func;
      end
      if (s2_adv) s2_v <= s1_v;
      if (s2_adv && s1_v) out_s <= s_comb;
    end
  end
endmodule

// File: doc/sym_lane_pipe.md
Name: sym_lane_pipe

Overview:
- Multi-lane, pipelined successor to the single-channel symmetry term generator.
- Each lane produces the symmetric correction term of an activation function from a fixed-point input and its sign flag.
- The function is selected per beat at runtime rather than by parameter.
- Sits between the fixed-point activation front end and the combine stage, with valid/ready flow control and full backpressure support.

Parameters:
- M, 4: integer bits of each lane word, sign bit included.
- N, 8: fractional bits of each lane word.
- LANES, 4: number of parallel lanes; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_x  input  LANES*(M+N)  signed lane words; lane i occupies bits [i*(M+N) +: M+N].
- in_sign  input  LANES  per-lane sign flag.
- in_func  input  2  function select for this beat, shared by all lanes.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_s  output  LANES*(M+N)  signed lane results, same packing as in_x.
- busy  output  1  at least one pipeline stage holds a beat.

Behaviour:
- Reset is synchronous and active-high; clock is clk. While rst is high at a rising edge, all valid flags clear, so out_valid=0 and busy=0 on the next cycle.
- Outputs after reset: out_s=0, in_ready=1 (combinational, as defined below).
- Data registers need no reset; out_s is nevertheless cleared on reset.
- Asserting rst mid-operation discards all in-flight beats with no output emitted; nothing is retained after reset deasserts.
- Transfers: an input transfer occurs when in_valid&in_ready is high; an output transfer occurs when out_valid&out_ready is high.
- Pipeline: two register stages.
  - S1 captures in_x, in_sign and in_func.
  - S2 holds the computed out_s.
  - Latency is 2 cycles from input transfer to out_valid, given no stall.
- Flow control:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv, combinational and dependent only on stage state and out_ready.
  - Full throughput is 1 beat/cycle when out_ready is held high.
- Stall: when out_ready is low and both stages are full, in_ready=0 and S1/S2 contents hold unchanged. No beat is dropped or duplicated.
- Simultaneous events: an output transfer and an input transfer in the same cycle with both stages full move all beats forward by one stage.
- in_func is captured per beat, so consecutive beats may use different functions.
- Per-lane function, with sign=0 always giving 0 in every mode:
  - 0: 0.
  - 1: sign ? (1<<N) : 0, i.e. +1.0.
  - 2: sign ? x : 0.
  - 3: sign ? -x : 0, computed in M+N+1 bits then reduced to M+N bits.
- Mode 1 when M=1: 1.0 is not representable; the result is the truncated value (1<<N) in M+N bits, and is documented as unsupported.
- Lanes are fully independent; there is no cross-lane arithmetic.
- busy = s1_v | s2_v.

Optional Feature:
- Macro: SYM_NEG_SAT_EN.
- Defined: in mode 3, negating the most negative value (-2^(M+N-1)) yields the maximum positive value 2^(M+N-1)-1. All other values negate exactly.
- Undefined: two's-complement wrap, so the most negative value negates to itself. No extra logic is generated.

Decomposition:
- Shared package sym_pkg holds:
  - Function codes SYM_F_ZERO=0, SYM_F_ONE=1, SYM_F_X=2, SYM_F_NEGX=3.
  - A helper that computes the lane word width from M and N.
- Sub-module sym_lane: a combinational per-lane compute taking x, sign, func and producing s, with the saturation macro applied inside it.
- The top instantiates LANES copies of sym_lane in a generate loop and owns the S1/S2 registers and the handshake logic.

Test Plan:
1. Basic: M=4, N=8, LANES=4; one beat with in_func=1 and in_sign=4'b1010 -> exactly 2 cycles later out_valid=1 and out_s lanes are {0x100, 0, 0x100, 0}, lane 3 first.
2. Mode 2/3: x=0x0A0 on all lanes with in_sign=4'b1111 -> mode 2 gives 0x0A0 and mode 3 gives 0xF60 on all lanes. With in_sign=0 both modes give 0.
3. Saturation: x=0x800, mode 3, sign=1 -> output 0x7FF with SYM_NEG_SAT_EN defined, 0x800 without it.
4. Backpressure: stream 8 beats with mode cycling 0..3 and out_ready=0 for cycles 3-6:
   - in_ready falls once both stages are full.
   - All 8 results arrive in order with the correct mode each.
   - No drops and no duplicates.
5. Throughput: out_ready=1 and in_valid=1 for 16 cycles -> 16 output transfers, one per cycle, starting in cycle 2.
6. Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, busy=0, in_ready=1, and none of the pre-reset beats is ever output.
